ddr3_wb_cache: RTL
==================

DDR3_WB_CACHE -- requirements
Module: ddr3_wb_cache

Interface
REQ-001 The block SHALL have parameter LINE_WORDS, default 4, meaning 32-bit words per line (power of two, 2..16).
REQ-002 The block SHALL have parameter NUM_SETS, default 256, meaning direct-mapped sets (power of two, 16..1024).
REQ-003 The block SHALL derive OFF_W=log2(LINE_WORDS) and IDX_W=log2(NUM_SETS); tag = address[31:2+OFF_W+IDX_W], index = address[2+OFF_W+IDX_W-1:2+OFF_W], word = address[2+OFF_W-1:2]; address[1:0] ignored.
REQ-004 The block SHALL have these ports (name direction width meaning): clk in 1 clock; reset_n in 1 asynchronous active-low reset.
REQ-005 address in 32 byte address; write_data in 32 store data; byte_en in 4 store byte lanes; read in 1 load request; write in 1 store request.
REQ-006 read_data out 32 load data; hit out 1 load data valid; stall out 1 requester must hold request; flush in 1 flush-all pulse; flush_done out 1 one-cycle completion pulse.
REQ-007 wr_fifo_full in 1; wr_fifo_push out 1; wr_fifo_addr out 32 line-aligned victim address; wr_fifo_data out 32*LINE_WORDS victim line, word 0 in bits [31:0].
REQ-008 rd_req_full in 1; rd_req_push out 1; rd_req_addr out 32 line-aligned refill address.
REQ-009 rd_rsp_empty in 1; rd_rsp_data in 32*LINE_WORDS refill line, word 0 in bits [31:0]; rd_rsp_pop out 1.

Function
REQ-010 The block SHALL implement states IDLE, WRITEBACK, REFILL_REQ, REFILL_WAIT, FLUSH.
REQ-011 read and write asserted together SHALL be treated as read; write is ignored.
REQ-012 stall SHALL be combinational: high when state != IDLE, or in IDLE when a request misses or flush work is pending; low otherwise.
REQ-013 IDLE read hit (valid and tag match): hit=1 and read_data=line word on the next cycle; hit=0 on every other cycle.
REQ-014 IDLE write hit: bytes selected by byte_en written at the clock edge, line dirty set; no stall.
REQ-015 IDLE miss with victim valid and dirty: go to WRITEBACK; otherwise go to REFILL_REQ (write-allocate for stores).
REQ-016 WRITEBACK: wr_fifo_push=1 for exactly one cycle in the first cycle with wr_fifo_full=0, addr={victim tag,index,0}, data=victim line; line dirty cleared; next REFILL_REQ. While wr_fifo_full=1 wait, push=0.
REQ-017 REFILL_REQ: rd_req_push=1 for one cycle when rd_req_full=0, addr={tag,index,0}; next REFILL_WAIT.
REQ-018 REFILL_WAIT: when rd_rsp_empty=0, rd_rsp_pop=1 for one cycle, line installed with new tag, valid=1, dirty=0; next IDLE, where the held request hits.
REQ-019 Only one outstanding miss SHALL exist; no rd_req_push while in REFILL_WAIT.
REQ-020 flush SHALL be latched into flush_pending in any state; acted on only from IDLE when no request is present (requests have priority).
REQ-021 FLUSH: walk index 0..NUM_SETS-1, one set per cycle; dirty valid sets push as in REQ-016 (waiting on full) and clear dirty; valid bits kept; after the last set, flush_done=1 one cycle, return IDLE.
REQ-022 A flush pulse during FLUSH SHALL re-arm flush_pending for one further pass.
REQ-023 Push/pop outputs SHALL be registered-free decodes of state and FIFO flags, never asserted in the same cycle as a full/empty violation.

Reset
REQ-024 reset_n low SHALL asynchronously clear state to IDLE, all valid and dirty bits, flush_pending, flush index, and drive read_data=0, hit=0, flush_done=0, all push/pop=0.
REQ-025 reset_n low mid-miss or mid-flush SHALL abort with no further FIFO pushes or pops; data arrays need no reset.

Verification
REQ-026 Cold read 0x0000_0040, rd_rsp holds line {4,3,2,1} -> one rd_req_push addr 0x40, one pop, then hit=1 read_data=1; stall low afterwards.
REQ-027 Store 0xDEADBEEF byte_en=0011 to 0x44 after REQ-026 fill, read 0x44 -> read_data=0x0000BEEF; no FIFO traffic.
REQ-028 Dirty line at index 4 tag A, read tag B same index with wr_fifo_full=1 for 5 cycles -> no push for 5 cycles, then one wr_fifo_push with tag-A address, then refill.
REQ-029 Three dirty sets, flush pulse -> exactly three wr_fifo_push, flush_done one pulse NUM_SETS+3 cycles or later, subsequent reads hit.
REQ-030 reset_n low during REFILL_WAIT -> all outputs zero immediately, next read of same address misses and re-requests.

Source files
------------

// File: rtl/ddr3_wb_cache.sv
// Direct-mapped, write-back, write-allocate cache in front of a DDR3 controller.
// A miss optionally writes back the dirty victim, then requests and installs the refill line.
module ddr3_wb_cache #(
  parameter int LINE_WORDS = 4,
  parameter int NUM_SETS   = 256
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [31:0]             address,
  input  logic [31:0]             write_data,
  input  logic [3:0]              byte_en,
  input  logic                    read,
  input  logic                    write,
  output logic [31:0]             read_data,
  output logic                    hit,
  output logic                    stall,
  input  logic                    flush,
  output logic                    flush_done,
  input  logic                    wr_fifo_full,
  output logic                    wr_fifo_push,
  output logic [31:0]             wr_fifo_addr,
  output logic [32*LINE_WORDS-1:0] wr_fifo_data,
  input  logic                    rd_req_full,
  output logic                    rd_req_push,
  output logic [31:0]             rd_req_addr,
  input  logic                    rd_rsp_empty,
  input  logic [32*LINE_WORDS-1:0] rd_rsp_data,
  output logic                    rd_rsp_pop
);
  localparam int OFF_W  = $clog2(LINE_WORDS);
  localparam int IDX_W  = $clog2(NUM_SETS);
  localparam int TAG_W  = 30 - OFF_W - IDX_W;
  localparam int LINE_W = 32 * LINE_WORDS;

  typedef enum logic [2:0] {IDLE, WRITEBACK, REFILL_REQ, REFILL_WAIT, FLUSH} state_t;

  state_t            state, state_n;
  logic [LINE_W-1:0] data_mem [NUM_SETS];
  logic [TAG_W-1:0]  tag_mem  [NUM_SETS];
  logic [NUM_SETS-1:0] valid_bits, dirty_bits;
  logic              flush_pending;
  logic [IDX_W-1:0]  flush_idx;

  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx, set_idx;
  logic [OFF_W-1:0]  req_word;
  logic [LINE_W-1:0] req_line;
  logic [31:0]       word_rd, word_wr;
  logic              req, tag_hit, victim_dirty, read_hit, write_hit;
  logic              flush_start, flush_adv, flush_last;
  logic              unused_addr_bits;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    return r;
  endfunction

  assign req_tag          = address[31:2+OFF_W+IDX_W];
  assign req_idx          = address[2+OFF_W+IDX_W-1:2+OFF_W];
  assign req_word         = address[2+OFF_W-1:2];
  assign unused_addr_bits = ^address[1:0];

  assign req_line     = data_mem[req_idx];
  assign word_rd      = req_line[{req_word, 5'd0} +: 32];
  assign word_wr      = merge_bytes(word_rd, write_data, byte_en);
  assign req          = read | write;
  assign tag_hit      = valid_bits[req_idx] && (tag_mem[req_idx] == req_tag);
  assign victim_dirty = valid_bits[req_idx] && dirty_bits[req_idx];
  // A simultaneous read and write is serviced as a read only.
  assign read_hit     = (state == IDLE) && read && tag_hit;
  assign write_hit    = (state == IDLE) && write && !read && tag_hit;
  assign flush_last   = (flush_idx == IDX_W'(NUM_SETS - 1));

  assign rd_req_addr  = {req_tag, req_idx, {(OFF_W+2){1'b0}}};
  assign wr_fifo_addr = {tag_mem[set_idx], set_idx, {(OFF_W+2){1'b0}}};
  assign wr_fifo_data = data_mem[set_idx];

  always_comb begin
    state_n      = state;
    stall        = 1'b0;
    wr_fifo_push = 1'b0;
    rd_req_push  = 1'b0;
    rd_rsp_pop   = 1'b0;
    flush_start  = 1'b0;
    flush_adv    = 1'b0;
    set_idx      = req_idx;
    unique case (state)
      IDLE: begin
        if (req) begin
          if (!tag_hit) begin
            stall   = 1'b1;
            state_n = victim_dirty ? WRITEBACK : REFILL_REQ;
          end
        end else if (flush_pending) begin
          stall       = 1'b1;
          flush_start = 1'b1;
          state_n     = FLUSH;
        end
      end
      WRITEBACK: begin
        stall = 1'b1;
        if (!wr_fifo_full) begin
          wr_fifo_push = 1'b1;
          state_n      = REFILL_REQ;
        end
      end
      REFILL_REQ: begin
        stall = 1'b1;
        if (!rd_req_full) begin
          rd_req_push = 1'b1;
          state_n     = REFILL_WAIT;
        end
      end
      REFILL_WAIT: begin
        stall = 1'b1;
        if (!rd_rsp_empty) begin
          rd_rsp_pop = 1'b1;
          state_n    = IDLE;
        end
      end
      FLUSH: begin
        stall   = 1'b1;
        set_idx = flush_idx;
        if (valid_bits[flush_idx] && dirty_bits[flush_idx]) begin
          if (!wr_fifo_full) begin
            wr_fifo_push = 1'b1;
            flush_adv    = 1'b1;
          end
        end else begin
          flush_adv = 1'b1;
        end
        if (flush_adv && flush_last) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      flush_pending <= 1'b0;
      flush_idx     <= '0;
      valid_bits    <= '0;
      dirty_bits    <= '0;
      read_data     <= '0;
      hit           <= 1'b0;
      flush_done    <= 1'b0;
    end else begin
      state <= state_n;
      // A pulse arriving while a pass is starting or running re-arms another pass.
      if (flush)            flush_pending <= 1'b1;
      else if (flush_start) flush_pending <= 1'b0;
      if (flush_start)    flush_idx <= '0;
      else if (flush_adv) flush_idx <= flush_idx + IDX_W'(1);
      flush_done <= flush_adv && flush_last;
      hit        <= read_hit;
      if (read_hit) read_data <= word_rd;
      if (rd_rsp_pop) begin
        valid_bits[req_idx] <= 1'b1;
        dirty_bits[req_idx] <= 1'b0;
      end
      if (write_hit)    dirty_bits[req_idx] <= 1'b1;
      if (wr_fifo_push) dirty_bits[set_idx] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_rsp_pop) begin
      data_mem[req_idx] <= rd_rsp_data;
      tag_mem[req_idx]  <= req_tag;
    end else if (write_hit) begin
      data_mem[req_idx][{req_word, 5'd0} +: 32] <= word_wr;
    end
  end
endmodule
